video_frame_sequencer: RTL and testbench

//  Playback controller that sits around the principal video memory. Generates rd_image/address_image, takes its 24-bit data_out back, and streams pixels to the panel driver over valid/ready.

---
 rtl/video_pkg.sv | 20 ++
 rtl/pix_skid_fifo.sv | 59 +++++
 rtl/video_frame_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_video_frame_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Constants and FSM encoding shared by the frame sequencer, the video memory and the panel driver.
package video_pkg;

    localparam int PIX_W        = 24;
    localparam int N_FRAMES     = 24;
    localparam int FRAME_PIXELS = 2048;
    localparam int FRAME_REPEAT = 60;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fsm_t;

    // Counter width that never collapses to zero bits for a count of 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry valid/ready FIFO carrying {last, pixel}; the head is always held in slot0.
module pix_skid_fifo
    import video_pkg::*;
#(
    parameter int WIDTH = PIX_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic             pop;

    assign out_valid = (count != 2'd0);
    assign out_data  = slot0;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case ({in_valid, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        slot0 <= in_data;
                        count <= 2'd1;
                    end else if (count == 2'd1) begin
                        slot1 <= in_data;
                        count <= 2'd2;
                    end
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever remains.
                    if (count == 2'd1) begin
                        slot0 <= in_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/video_frame_sequencer.sv
// Frame playback controller: sweeps video memory frame by frame and streams words to the panel.
// Optional ping-pong frame order is built when VSEQ_BOUNCE_EN is defined.
module video_frame_sequencer #(
    parameter int N_FRAMES     = video_pkg::N_FRAMES,
    parameter int FRAME_PIXELS = video_pkg::FRAME_PIXELS,
    parameter int FRAME_REPEAT = video_pkg::FRAME_REPEAT,
    parameter int AW           = $clog2(N_FRAMES * FRAME_PIXELS),
    localparam int FW          = video_pkg::cnt_w(N_FRAMES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        play,
    input  logic                        restart,
    output logic                        rd_image,
    output logic [AW-1:0]               address_image,
    input  logic [video_pkg::PIX_W-1:0] mem_data,
    output logic [video_pkg::PIX_W-1:0] pix_data,
    output logic                        pix_valid,
    input  logic                        pix_ready,
    output logic                        pix_last,
    output logic [FW-1:0]               frame_idx
);

    import video_pkg::*;

    localparam int PCW = cnt_w(FRAME_PIXELS);
    localparam int RW  = cnt_w(FRAME_REPEAT);

    localparam logic [PCW-1:0] PIX_MAX   = PCW'(FRAME_PIXELS - 1);
    localparam logic [RW-1:0]  REP_MAX   = RW'(FRAME_REPEAT - 1);
    localparam logic [FW-1:0]  FRM_MAX   = FW'(N_FRAMES - 1);
    localparam logic [AW-1:0]  BASE_STEP = AW'(FRAME_PIXELS);

    fsm_t           state, state_n;
    logic [PCW-1:0] pix_cnt, pix_cnt_n;
    logic [AW-1:0]  frame_base, frame_base_n;
    logic [AW-1:0]  address_n;
    logic [FW-1:0]  frame_n;
    logic [RW-1:0]  rep_cnt, rep_n;
    logic           restart_lat, restart_lat_n;
    logic           rd_n;
    logic           last_n;
    logic           last_p1;
    logic           pop;
    logic           can_issue;
    logic [1:0]     fifo_count;
    logic [PIX_W:0] head;
`ifdef VSEQ_BOUNCE_EN
    logic           fwd, fwd_n;
`endif

    assign pop = pix_valid && pix_ready;
    // A word popped this cycle frees a slot in time for a read issued now.
    assign can_issue = ({1'b0, fifo_count} + {2'b00, rd_image}) < (3'd2 + {2'b00, pop});

    always_comb begin
        state_n       = state;
        pix_cnt_n     = pix_cnt;
        frame_base_n  = frame_base;
        frame_n       = frame_idx;
        rep_n         = rep_cnt;
        restart_lat_n = restart_lat | restart;
        rd_n          = 1'b0;
        last_n        = 1'b0;
        address_n     = address_image;
`ifdef VSEQ_BOUNCE_EN
        fwd_n         = fwd;
`endif
        case (state)
            IDLE: begin
                if (en) state_n = RUN;
            end
            RUN: begin
                if (can_issue) begin
                    rd_n      = 1'b1;
                    address_n = frame_base + AW'(pix_cnt);
                    if (pix_cnt == PIX_MAX) begin
                        last_n    = 1'b1;
                        pix_cnt_n = '0;
                        state_n   = DRAIN;
                    end else begin
                        pix_cnt_n = pix_cnt + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Only the tagged last word of this sweep can be at the head with pix_last set.
                if (pop && pix_last) begin
                    state_n = en ? RUN : IDLE;
                    if (restart_lat_n) begin
                        frame_n       = '0;
                        frame_base_n  = '0;
                        rep_n         = '0;
                        restart_lat_n = 1'b0;
`ifdef VSEQ_BOUNCE_EN
                        fwd_n         = 1'b1;
`endif
                    end else if (rep_cnt == REP_MAX) begin
                        rep_n = '0;
                        if (play) begin
`ifdef VSEQ_BOUNCE_EN
                            if (N_FRAMES > 1) begin
                                if (fwd ? (frame_idx == FRM_MAX) : (frame_idx != '0)) begin
                                    fwd_n        = 1'b0;
                                    frame_n      = frame_idx - 1'b1;
                                    frame_base_n = frame_base - BASE_STEP;
                                end else begin
                                    fwd_n        = 1'b1;
                                    frame_n      = frame_idx + 1'b1;
                                    frame_base_n = frame_base + BASE_STEP;
                                end
                            end
`else
                            if (frame_idx == FRM_MAX) begin
                                frame_n      = '0;
                                frame_base_n = '0;
                            end else begin
                                frame_n      = frame_idx + 1'b1;
                                frame_base_n = frame_base + BASE_STEP;
                            end
`endif
                        end
                    end else begin
                        rep_n = rep_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Stage p0: issue the read; the memory answers on the following edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pix_cnt       <= '0;
            frame_base    <= '0;
            frame_idx     <= '0;
            rep_cnt       <= '0;
            restart_lat   <= 1'b0;
            rd_image      <= 1'b0;
            address_image <= '0;
            last_p1       <= 1'b0;
        end else begin
            state         <= state_n;
            pix_cnt       <= pix_cnt_n;
            frame_base    <= frame_base_n;
            frame_idx     <= frame_n;
            rep_cnt       <= rep_n;
            restart_lat   <= restart_lat_n;
            rd_image      <= rd_n;
            address_image <= address_n;
            last_p1       <= last_n;
        end
    end

`ifdef VSEQ_BOUNCE_EN
    always_ff @(posedge clk) begin
        if (rst) fwd <= 1'b1;
        else     fwd <= fwd_n;
    end
`endif

    // Stage p1: memory word arrives together with its last tag.
    pix_skid_fifo #(
        .WIDTH(PIX_W + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .in_valid (rd_image),
        .in_data  ({last_p1, mem_data}),
        .out_valid(pix_valid),
        .out_data (head),
        .out_ready(pix_ready),
        .count    (fifo_count)
    );

    assign pix_data = head[PIX_W-1:0];
    assign pix_last = pix_valid & head[PIX_W];

endmodule

// File: tb/tb_video_frame_sequencer.sv
// Scoreboard bench for video_frame_sequencer; with VSEQ_BOUNCE_EN defined it runs repeat=1 ping-pong order.
module tb_video_frame_sequencer;

    localparam int NF = 3;
    localparam int FP = 8;
`ifdef VSEQ_BOUNCE_EN
    localparam int REP = 1;
`else
    localparam int REP = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        play = 1'b0;
    logic        restart = 1'b0;
    logic        rd_image;
    logic [4:0]  address_image;
    logic [23:0] mem_data = '0;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        pix_last;
    logic [1:0]  frame_idx;

    video_frame_sequencer #(
        .N_FRAMES    (NF),
        .FRAME_PIXELS(FP),
        .FRAME_REPEAT(REP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .play         (play),
        .restart      (restart),
        .rd_image     (rd_image),
        .address_image(address_image),
        .mem_data     (mem_data),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_last     (pix_last),
        .frame_idx    (frame_idx)
    );

    always #5 clk = ~clk;

    // Memory: registers the request on the falling edge, word content = address.
    always @(negedge clk) if (rd_image) mem_data <= 24'(address_image);

    bit rand_rdy = 1'b0;
    always @(posedge clk) begin
        #1;
        pix_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int          m_frame = 0;
    int          m_rep = 0;
    bit          m_dir = 1'b1;
    bit          m_rlat = 1'b0;
    logic [24:0] sb_q[$];
    int          starts[$];
    int          acc_cnt = 0;
    int          last_cnt = 0;
    int          last_data = -1;
    bit          prev_stall = 1'b0;
    logic [24:0] prev_word = '0;

    function automatic void step_frame();
`ifdef VSEQ_BOUNCE_EN
        if (m_dir) begin
            if (m_frame == NF - 1) begin m_dir = 1'b0; m_frame = m_frame - 1; end
            else m_frame = m_frame + 1;
        end else begin
            if (m_frame == 0) begin m_dir = 1'b1; m_frame = m_frame + 1; end
            else m_frame = m_frame - 1;
        end
`else
        m_frame = (m_frame + 1) % NF;
`endif
    endfunction

    function automatic void model_boundary();
        if (m_rlat) begin
            m_frame = 0; m_rep = 0; m_dir = 1'b1; m_rlat = 1'b0;
        end else if (m_rep == REP - 1) begin
            m_rep = 0;
            if (play) step_frame();
        end else begin
            m_rep++;
        end
    endfunction

    always @(negedge clk) begin
        logic [24:0] e;
        if (rst) begin
            sb_q.delete(); starts.delete();
            m_frame = 0; m_rep = 0; m_dir = 1'b1; m_rlat = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk_eq("stall_valid", 32'(pix_valid), 32'd1);
                chk_eq("stall_word", 32'({pix_last, pix_data}), 32'(prev_word));
            end
            if (restart) m_rlat = 1'b1;
            if (pix_valid && pix_ready) begin
                if (sb_q.size() == 0) begin
                    for (int p = 0; p < FP; p++)
                        sb_q.push_back({(p == FP - 1) ? 1'b1 : 1'b0, 24'(m_frame * FP + p)});
                    starts.push_back(m_frame);
                    chk_eq("frame_idx", 32'(frame_idx), m_frame);
                end
                e = sb_q.pop_front();
                chk_eq("pix_word", 32'({pix_last, pix_data}), 32'(e));
                acc_cnt++;
                last_data = int'(pix_data);
                if (e[24]) begin
                    last_cnt++;
                    model_boundary();
                end
            end
            prev_stall = pix_valid && !pix_ready;
            prev_word  = {pix_last, pix_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_words(input int n, input int budget);
        int tgt;
        int c;
        tgt = acc_cnt + n;
        c = 0;
        while (acc_cnt < tgt && c < budget) begin tick(); c++; end
        if (acc_cnt < tgt) chk_eq("wait_timeout", 32'(acc_cnt), 32'(tgt));
    endtask

    task automatic check_all_zero(input string tag);
        chk_eq({tag, "_rd"}, 32'(rd_image), 32'd0);
        chk_eq({tag, "_addr"}, 32'(address_image), 32'd0);
        chk_eq({tag, "_valid"}, 32'(pix_valid), 32'd0);
        chk_eq({tag, "_data"}, 32'(pix_data), 32'd0);
        chk_eq({tag, "_last"}, 32'(pix_last), 32'd0);
        chk_eq({tag, "_frame"}, 32'(frame_idx), 32'd0);
    endtask

    initial begin
        int cyc;
        int c;
        int t0;
        int lc0;
        bit any_rd;
        bit any_vld;
        int exp_starts[6];
`ifdef VSEQ_BOUNCE_EN
        exp_starts = '{0, 1, 2, 1, 0, 1};
`else
        exp_starts = '{0, 0, 1, 1, 2, 2};
`endif

        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Start-up latency and straight playback
        en = 1'b1; play = 1'b1;
        cyc = 0;
        do begin tick(); cyc++; end while (!pix_valid && cyc < 10);
        chk_eq("first_valid_latency", 32'(cyc), 32'd3);
        wait_words(56, 400);
        if (starts.size() < 6) chk_eq("sweep_count", 32'(starts.size()), 32'd6);
        else for (int i = 0; i < 6; i++) chk_eq("sweep_start", 32'(starts[i]), 32'(exp_starts[i]));

        // Random back-pressure
        rand_rdy = 1'b1;
        wait_words(48, 2000);
        rand_rdy = 1'b0;

        // Pause in the middle of frame 1
        c = 0;
        while (!(m_frame == 1 && sb_q.size() >= 2 && sb_q.size() <= 6) && c < 500) begin tick(); c++; end
        chk_eq("reach_frame1", 32'(m_frame), 32'd1);
        play = 1'b0;
        wait_words(40, 400);
        play = 1'b1;
        wait_words(24, 400);

        // Restart requested during word 19
        t0 = acc_cnt; c = 0;
        while (!(acc_cnt > t0 && last_data == 19) && c < 1000) begin tick(); c++; end
        chk_eq("reach_word19", 32'(last_data), 32'd19);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        lc0 = last_cnt; c = 0;
        while (last_cnt == lc0 && c < 200) begin tick(); c++; end
        chk_eq("restart_sweep_end", 32'(last_data), 32'd23);
        t0 = acc_cnt; c = 0;
        while (acc_cnt == t0 && c < 200) begin tick(); c++; end
        chk_eq("restart_first_word", 32'(last_data), 32'd0);
        chk_eq("restart_frame_idx", 32'(frame_idx), 32'd0);
        wait_words(16, 200);

        // Disable mid-frame: sweep completes, then reads stop
        c = 0;
        while (!(sb_q.size() >= 2 && sb_q.size() <= 6) && c < 200) begin tick(); c++; end
        en = 1'b0;
        lc0 = last_cnt; c = 0;
        while (last_cnt == lc0 && c < 200) begin tick(); c++; end
        chk_eq("disable_sweep_done", 32'(last_cnt), 32'(lc0 + 1));
        any_rd = 1'b0; any_vld = 1'b0;
        repeat (20) begin tick(); any_rd |= rd_image; any_vld |= pix_valid; end
        chk_eq("idle_rd", 32'(any_rd), 32'd0);
        chk_eq("idle_valid", 32'(any_vld), 32'd0);

        // Reset in the middle of a frame
        en = 1'b1;
        wait_words(5, 200);
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        tick();
        chk_eq("post_rst_valid", 32'(pix_valid), 32'd0);
        wait_words(20, 300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
